// File: rtl/adc_level_monitor_pkg.sv
// Shared constants and types for the ADC level monitor: config register
// map, threshold-mode encoding and a small address-decode helper.
package adc_mon_pkg;

    localparam logic [3:0] CFG_WIN_LEN  = 4'd0;
    localparam logic [3:0] CFG_OVFL_THR = 4'd1;
    localparam logic [3:0] CFG_RUN_LEN  = 4'd2;
    localparam logic [3:0] CFG_THR_BASE = 4'd4;

    // Bit of the threshold config word that selects the counting mode
    localparam int THR_MODE_BIT = 31;

    typedef enum logic {
        THR_MODE_LEVEL = 1'b0,  // count samples whose magnitude >= level
        THR_MODE_OVFL  = 1'b1   // count samples flagged by the ADC as overflow
    } thr_mode_e;

    // Writes to the window length or overflow threshold abort the current window
    function automatic logic cfg_is_restart(input logic [3:0] addr);
        return (addr == CFG_WIN_LEN) || (addr == CFG_OVFL_THR);
    endfunction

endpackage

// File: rtl/adc_level_monitor_thr_ctr.sv
// One threshold channel: a level/mode config register and a wrapping event
// counter fed by the S2 stage of the monitor pipeline.
module adc_thr_ctr
    import adc_mon_pkg::*;
#(
    parameter int ADC_BITS = 14,
    parameter int CNT_BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr,
    input  logic [31:0]         i_wdata,
    input  logic                i_clr,
    input  logic                i_vld,
    input  logic [ADC_BITS-2:0] i_mag,
    input  logic                i_ovfl,
    output logic [CNT_BITS-1:0] o_count
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [ADC_BITS-2:0] r_level;
    thr_mode_e           r_mode;
    logic [CNT_BITS-1:0] r_count;
    logic                w_hit;
    logic                w_unused_wdata;

    // Only the level field and the mode bit of the write word are meaningful
    assign w_unused_wdata = ^i_wdata;

    // Threshold configuration register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= {(ADC_BITS-1){1'b1}};
            r_mode  <= THR_MODE_LEVEL;
        end else if (i_wr) begin
            r_level <= i_wdata[ADC_BITS-2:0];
            r_mode  <= thr_mode_e'(i_wdata[THR_MODE_BIT]);
        end else begin
            r_level <= r_level;
            r_mode  <= r_mode;
        end
    end

    // Event condition for the sample currently in S2
    always_comb begin
        w_hit = 1'b0;
        if (i_vld) begin
            case (r_mode)
                THR_MODE_LEVEL: w_hit = (i_mag >= r_level);
                THR_MODE_OVFL:  w_hit = i_ovfl;
                default:        w_hit = 1'b0;
            endcase
        end else begin
            w_hit = 1'b0;
        end
    end

    // Event counter: global clear beats config clear beats increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_BITS{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_BITS{1'b0}};
        end else if (i_wr) begin
            r_count <= {CNT_BITS{1'b0}};
        end else if (w_hit) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/adc_level_monitor.sv
// ADC overflow / level monitor in the adc_clk domain. Three-stage pipeline:
// S0 captures the sample, S1 forms a saturated magnitude, S2 updates the
// measurement window, the overflow run detector and the threshold counters.
module adc_level_monitor
    import adc_mon_pkg::*;
#(
    parameter int ADC_BITS = 14,
    parameter int WIN_BITS = 16,
    parameter int CNT_BITS = 32,
    parameter int N_THR    = 4,
    parameter int RUN_BITS = 16
) (
    input  logic                      adc_clk,
    input  logic                      rst_n,
    input  logic signed [ADC_BITS-1:0] adc_data,
    input  logic                      adc_ovfl,
    input  logic                      cfg_wr,
    input  logic [3:0]                cfg_addr,
    input  logic [31:0]               cfg_data,
    input  logic                      cnt_clr,
    output logic [N_THR*CNT_BITS-1:0] thr_count,
    output logic                      win_done,
    output logic                      ovfl_flag,
    output logic                      ovfl_run,
    output logic [ADC_BITS-2:0]       peak_mag
);

    localparam logic [ADC_BITS-2:0]        MAG_MAX  = {(ADC_BITS-1){1'b1}};
    localparam logic signed [ADC_BITS-1:0] ADC_MIN  = {1'b1, {(ADC_BITS-1){1'b0}}};
    localparam logic [ADC_BITS-1:0]        ADC_ONE  = {{(ADC_BITS-1){1'b0}}, 1'b1};
    localparam logic [WIN_BITS-1:0]        WIN_MAX  = {WIN_BITS{1'b1}};
    localparam logic [WIN_BITS-1:0]        WIN_ONE  = {{(WIN_BITS-1){1'b0}}, 1'b1};
    localparam logic [WIN_BITS-1:0]        WIN_ZERO = {WIN_BITS{1'b0}};
    localparam logic [RUN_BITS-1:0]        RUN_MAX  = {RUN_BITS{1'b1}};
    localparam logic [RUN_BITS-1:0]        RUN_ONE  = {{(RUN_BITS-1){1'b0}}, 1'b1};
    localparam logic [RUN_BITS-1:0]        RUN_ZERO = {RUN_BITS{1'b0}};

    // |x| with the most-negative code clamped so it never wraps to zero
    function automatic logic [ADC_BITS-2:0] sat_mag(input logic signed [ADC_BITS-1:0] x);
        logic [ADC_BITS-1:0] neg;
        neg = ~x + ADC_ONE;
        if (x == ADC_MIN) begin
            return MAG_MAX;
        end else if (x[ADC_BITS-1]) begin
            return neg[ADC_BITS-2:0];
        end else begin
            return x[ADC_BITS-2:0];
        end
    endfunction

    // Pipeline registers
    logic signed [ADC_BITS-1:0] r_data_s0;
    logic                       r_ovfl_s0;
    logic                       r_vld_s0;
    logic [ADC_BITS-2:0]        r_mag_s1;
    logic                       r_ovfl_s1;
    logic                       r_vld_s1;

    // Configuration
    logic [WIN_BITS-1:0] r_win_len;
    logic [WIN_BITS-1:0] r_ovfl_thr;
    logic [RUN_BITS-1:0] r_run_len;

    // Window / run state and registered outputs
    logic [WIN_BITS-1:0] r_win_cnt;
    logic [WIN_BITS-1:0] r_ovfl_cnt;
    logic [ADC_BITS-2:0] r_peak_acc;
    logic [RUN_BITS-1:0] r_run_ctr;
    logic                r_win_done;
    logic                r_ovfl_flag;
    logic                r_ovfl_run;
    logic [ADC_BITS-2:0] r_peak_mag;

    // Combinational S2 terms
    logic                w_restart;
    logic [N_THR-1:0]    w_thr_wr;
    logic                w_last;
    logic [WIN_BITS-1:0] w_ocnt_nxt;
    logic [ADC_BITS-2:0] w_peak_nxt;
    logic [RUN_BITS-1:0] w_run_nxt;
    logic                w_flag;
    logic                w_run_hit;
    logic                w_unused_cfg;

    // Upper config bits are only used by some registers
    assign w_unused_cfg = ^cfg_data;

    // S0: capture the raw sample; valid marks real data after reset
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_s0 <= {ADC_BITS{1'b0}};
            r_ovfl_s0 <= 1'b0;
            r_vld_s0  <= 1'b0;
        end else begin
            r_data_s0 <= adc_data;
            r_ovfl_s0 <= adc_ovfl;
            r_vld_s0  <= 1'b1;
        end
    end

    // S1: saturated magnitude
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_s1  <= {(ADC_BITS-1){1'b0}};
            r_ovfl_s1 <= 1'b0;
            r_vld_s1  <= 1'b0;
        end else begin
            r_mag_s1  <= sat_mag(r_data_s0);
            r_ovfl_s1 <= r_ovfl_s0;
            r_vld_s1  <= r_vld_s0;
        end
    end

    // Config write decode: window restart and per-channel threshold writes
    always_comb begin
        w_restart = 1'b0;
        w_thr_wr  = {N_THR{1'b0}};
        if (cfg_wr) begin
            w_restart = cfg_is_restart(cfg_addr);
            for (int k = 0; k < N_THR; k++) begin
                w_thr_wr[k] = (cfg_addr == (CFG_THR_BASE + 4'(k)));
            end
        end else begin
            w_restart = 1'b0;
        end
    end

    // Configuration registers
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len  <= WIN_MAX;
            r_ovfl_thr <= WIN_ONE;
            r_run_len  <= RUN_ZERO;
        end else if (cfg_wr) begin
            case (cfg_addr)
                CFG_WIN_LEN:  r_win_len  <= cfg_data[WIN_BITS-1:0];
                CFG_OVFL_THR: r_ovfl_thr <= cfg_data[WIN_BITS-1:0];
                CFG_RUN_LEN:  r_run_len  <= cfg_data[RUN_BITS-1:0];
                default: begin
                    r_win_len  <= r_win_len;
                    r_ovfl_thr <= r_ovfl_thr;
                    r_run_len  <= r_run_len;
                end
            endcase
        end else begin
            r_win_len  <= r_win_len;
            r_ovfl_thr <= r_ovfl_thr;
            r_run_len  <= r_run_len;
        end
    end

    // Next-state terms for window accumulators and run detector
    always_comb begin
        w_last     = (r_win_cnt == r_win_len);
        w_ocnt_nxt = r_ovfl_cnt;
        w_peak_nxt = r_peak_acc;
        w_run_nxt  = r_run_ctr;
        if (r_ovfl_s1 && (r_ovfl_cnt != WIN_MAX)) begin
            w_ocnt_nxt = r_ovfl_cnt + WIN_ONE;
        end else begin
            w_ocnt_nxt = r_ovfl_cnt;
        end
        if (r_mag_s1 > r_peak_acc) begin
            w_peak_nxt = r_mag_s1;
        end else begin
            w_peak_nxt = r_peak_acc;
        end
        if (!r_ovfl_s1) begin
            w_run_nxt = RUN_ZERO;
        end else if (r_run_ctr != RUN_MAX) begin
            w_run_nxt = r_run_ctr + RUN_ONE;
        end else begin
            w_run_nxt = r_run_ctr;
        end
        w_flag    = (r_ovfl_thr != WIN_ZERO) && (w_ocnt_nxt >= r_ovfl_thr);
        w_run_hit = (r_run_len != RUN_ZERO) && (w_run_nxt >= r_run_len);
    end

    // Measurement window: count samples, close the window and publish results
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= WIN_ZERO;
            r_ovfl_cnt  <= WIN_ZERO;
            r_peak_acc  <= {(ADC_BITS-1){1'b0}};
            r_win_done  <= 1'b0;
            r_ovfl_flag <= 1'b0;
            r_peak_mag  <= {(ADC_BITS-1){1'b0}};
        end else if (w_restart) begin
            // Aborted window: drop this S2 sample, no done pulse, keep last peak
            r_win_cnt   <= WIN_ZERO;
            r_ovfl_cnt  <= WIN_ZERO;
            r_peak_acc  <= {(ADC_BITS-1){1'b0}};
            r_win_done  <= 1'b0;
            r_ovfl_flag <= 1'b0;
            r_peak_mag  <= r_peak_mag;
        end else if (r_vld_s1) begin
            if (w_last) begin
                r_win_cnt   <= WIN_ZERO;
                r_ovfl_cnt  <= WIN_ZERO;
                r_peak_acc  <= {(ADC_BITS-1){1'b0}};
                r_win_done  <= 1'b1;
                r_ovfl_flag <= w_flag;
                r_peak_mag  <= w_peak_nxt;
            end else begin
                r_win_cnt   <= r_win_cnt + WIN_ONE;
                r_ovfl_cnt  <= w_ocnt_nxt;
                r_peak_acc  <= w_peak_nxt;
                r_win_done  <= 1'b0;
                r_ovfl_flag <= 1'b0;
                r_peak_mag  <= r_peak_mag;
            end
        end else begin
            r_win_done  <= 1'b0;
            r_ovfl_flag <= 1'b0;
        end
    end

    // Consecutive-overflow run detector
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_ctr  <= RUN_ZERO;
            r_ovfl_run <= 1'b0;
        end else if (r_vld_s1) begin
            r_run_ctr  <= w_run_nxt;
            r_ovfl_run <= w_run_hit;
        end else begin
            r_run_ctr  <= r_run_ctr;
            r_ovfl_run <= r_ovfl_run;
        end
    end

    adc_thr_ctr #(
        .ADC_BITS (ADC_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_thr [N_THR-1:0] (
        .i_clk   (adc_clk),
        .i_rst_n (rst_n),
        .i_wr    (w_thr_wr),
        .i_wdata (cfg_data),
        .i_clr   (cnt_clr),
        .i_vld   (r_vld_s1),
        .i_mag   (r_mag_s1),
        .i_ovfl  (r_ovfl_s1),
        .o_count (thr_count)
    );

    assign win_done  = r_win_done;
    assign ovfl_flag = r_ovfl_flag;
    assign ovfl_run  = r_ovfl_run;
    assign peak_mag  = r_peak_mag;

endmodule
